// File: rtl/reg_file_cfg.sv
// Parametrised configuration register file with masked writes, read-only protection,
// pipelined reads (1 or 2 cycle latency), error flagging and per-export change pulses.
module reg_file_cfg #(
    parameter int unsigned                 REG_WIDTH    = 8,
    parameter int unsigned                 ADDR_WIDTH   = 4,
    parameter int unsigned                 DEPTH        = 16,
    parameter int unsigned                 NUM_EXPORT   = 4,
    parameter int unsigned                 RD_LATENCY   = 1,
    parameter logic [DEPTH*REG_WIDTH-1:0] RESET_VALUES =
        (DEPTH*REG_WIDTH)'(32) << (3 * REG_WIDTH),
    parameter logic [DEPTH-1:0]           RO_MASK      = '0
) (
    input  logic                           i_CLK,
    input  logic                           i_RST,
    input  logic                           i_WrEn,
    input  logic                           i_RdEn,
    input  logic [ADDR_WIDTH-1:0]          i_Address,
    input  logic [REG_WIDTH-1:0]           i_WrData,
    input  logic [REG_WIDTH-1:0]           i_WrMask,
    output logic [REG_WIDTH-1:0]           o_RdData,
    output logic                           o_RdData_Valid,
    output logic                           o_Err,
    output logic [NUM_EXPORT*REG_WIDTH-1:0] o_Exports,
    output logic [NUM_EXPORT-1:0]          o_Changed
);

    logic [REG_WIDTH-1:0]  regs_q [DEPTH];
    logic [REG_WIDTH-1:0]  rd_val;
    logic [REG_WIDTH-1:0]  wr_val;
    logic [DEPTH-1:0]      wr_sel;
    logic [NUM_EXPORT-1:0] chg_d;
    logic                  addr_hit;
    logic                  addr_ro;
    logic                  wr_ok;
    logic                  wr_err;
    logic                  rd_req;
    logic                  rd_err;

    // Full compare against every implemented index so out-of-range addresses never alias.
    always_comb begin
        rd_val   = '0;
        addr_hit = 1'b0;
        addr_ro  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_Address == ADDR_WIDTH'(k)) begin
                rd_val   = regs_q[k];
                addr_hit = 1'b1;
                addr_ro  = RO_MASK[k];
            end
        end
    end

    assign wr_ok  = i_WrEn & addr_hit & ~addr_ro;
    assign wr_err = i_WrEn & ~(addr_hit & ~addr_ro);
    assign rd_req = i_RdEn & ~i_WrEn;
    assign rd_err = ~addr_hit;
    assign wr_val = (rd_val & ~i_WrMask) | (i_WrData & i_WrMask);

    always_comb begin
        wr_sel = '0;
        chg_d  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_sel[k] = wr_ok && (i_Address == ADDR_WIDTH'(k));
        end
        for (int k = 0; k < NUM_EXPORT; k++) begin
            chg_d[k] = wr_sel[k] && (wr_val != regs_q[k]);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= RESET_VALUES[k*REG_WIDTH +: REG_WIDTH];
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_sel[k]) begin
                    regs_q[k] <= wr_val;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_EXPORT; k++) begin : g_export
        assign o_Exports[k*REG_WIDTH +: REG_WIDTH] = regs_q[k];
    end

    // Read request as seen one stage before the output register.
    logic                 pre_vld;
    logic                 pre_err;
    logic [REG_WIDTH-1:0] pre_data;

    if (RD_LATENCY == 2) begin : g_lat2
        logic                 s_vld_q;
        logic                 s_err_q;
        logic [REG_WIDTH-1:0] s_data_q;

        always_ff @(posedge i_CLK or negedge i_RST) begin
            if (!i_RST) begin
                s_vld_q  <= 1'b0;
                s_err_q  <= 1'b0;
                s_data_q <= '0;
            end else begin
                s_vld_q  <= rd_req;
                s_err_q  <= rd_err;
                s_data_q <= rd_val;
            end
        end

        assign pre_vld  = s_vld_q;
        assign pre_err  = s_err_q;
        assign pre_data = s_data_q;
    end else begin : g_lat1
        assign pre_vld  = rd_req;
        assign pre_err  = rd_err;
        assign pre_data = rd_val;
    end

    logic                  vld_q;
    logic                  err_q;
    logic [REG_WIDTH-1:0]  data_q;
    logic [NUM_EXPORT-1:0] chg_q;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            chg_q  <= '0;
        end else begin
            vld_q  <= pre_vld;
            err_q  <= wr_err | (pre_vld & pre_err);
            data_q <= pre_vld ? pre_data : '0;
            chg_q  <= chg_d;
        end
    end

    assign o_RdData       = data_q;
    assign o_RdData_Valid = vld_q;
    assign o_Err          = err_q;
    assign o_Changed      = chg_q;

endmodule

// File: tb/tb_reg_file_cfg.sv
// Scoreboard bench: dut_a uses defaults (latency 1), dut_b has DEPTH=12, latency 2 and
// reg3 read-only. Expected reads are queued at issue time and checked by a monitor.
module tb_reg_file_cfg;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    localparam logic [95:0] RV_B = {8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77, 8'h66,
                                    8'h55, 8'h44, 8'd32, 8'h00, 8'h00, 8'h00};

    logic       clk = 1'b0;
    int         cyc = 0;
    logic       rst_n [2];
    logic       wr_en [2];
    logic       rd_en [2];
    logic [3:0] addr  [2];
    logic [7:0] wdata [2];
    logic [7:0] wmask [2];

    logic [7:0]  a_data, b_data;
    logic        a_vld, b_vld, a_err, b_err;
    logic [31:0] a_exp, b_exp;
    logic [3:0]  a_chg, b_chg;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_cnt [2];
    int   chg_cnt [2][4];

    reg_file_cfg dut_a (
        .i_CLK(clk), .i_RST(rst_n[0]), .i_WrEn(wr_en[0]), .i_RdEn(rd_en[0]),
        .i_Address(addr[0]), .i_WrData(wdata[0]), .i_WrMask(wmask[0]),
        .o_RdData(a_data), .o_RdData_Valid(a_vld), .o_Err(a_err),
        .o_Exports(a_exp), .o_Changed(a_chg)
    );

    reg_file_cfg #(
        .DEPTH(12), .RD_LATENCY(2), .RESET_VALUES(RV_B), .RO_MASK(12'h008)
    ) dut_b (
        .i_CLK(clk), .i_RST(rst_n[1]), .i_WrEn(wr_en[1]), .i_RdEn(rd_en[1]),
        .i_Address(addr[1]), .i_WrData(wdata[1]), .i_WrMask(wmask[1]),
        .o_RdData(b_data), .o_RdData_Valid(b_vld), .o_Err(b_err),
        .o_Exports(b_exp), .o_Changed(b_chg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_port(input int d, input logic v, input logic [7:0] dat,
                              input logic e, input logic [3:0] ch);
        exp_t x;
        if (e) err_cnt[d]++;
        for (int k = 0; k < 4; k++) if (ch[k]) chg_cnt[d][k]++;
        n_cmp++;
        if (v) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_bad++;
                $display("FAIL unexpected_valid dut%0d: got valid data=%h, required no valid",
                         d, dat);
            end else begin
                x = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (dat !== x.data || e !== x.err || cyc != x.cyc) begin
                    n_bad++;
                    $display("FAIL read_dut%0d: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                             d, dat, e, cyc, x.data, x.err, x.cyc);
                end
            end
        end else if (dat !== 8'h00) begin
            n_bad++;
            $display("FAIL idle_data_dut%0d: got %h, required 00", d, dat);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_port(0, a_vld, a_data, a_err, a_chg);
            check_port(1, b_vld, b_data, b_err, b_chg);
        end
    end

    // Drive one cycle of stimulus; queue the expected read response when a read is issued.
    task automatic op(input int d, input logic we, input logic re, input logic [3:0] a,
                      input logic [7:0] dat, input logic [7:0] m,
                      input logic [7:0] ed, input logic ee);
        exp_t x;
        wr_en[d] = we; rd_en[d] = re; addr[d] = a; wdata[d] = dat; wmask[d] = m;
        if (re && !we) begin
            x.data = ed; x.err = ee; x.cyc = cyc + ((d == 0) ? 1 : 2);
            if (d == 0) q0.push_back(x); else q1.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1'b0; rd_en[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wmask[d] = '0;
        end
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk({name, "_pending"}, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1; err_cnt[d] = 0;
            for (int k = 0; k < 4; k++) chg_cnt[d][k] = 0;
        end
        idle(0);
        #2;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #1;
        chk("rst_valid", 32'(a_vld), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_changed", 32'(a_chg), 32'd0);
        chk("rst_exports_a", a_exp, 32'h2000_0000);
        chk("rst_exports_b", b_exp, 32'h2000_0000);
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Default contents, latency 1.
        op(0, 0, 1, 4'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        op(0, 0, 1, 4'd1, 8'h00, 8'h00, 8'h00, 1'b0);
        op(0, 0, 1, 4'd2, 8'h00, 8'h00, 8'h00, 1'b0);
        op(0, 0, 1, 4'd3, 8'h00, 8'h00, 8'd32, 1'b0);
        idle(1);
        drain("defaults");

        // Masked writes and change pulses.
        op(0, 1, 0, 4'd1, 8'hFF, 8'hFF, 8'h00, 1'b0);
        op(0, 1, 0, 4'd1, 8'hA5, 8'h0F, 8'h00, 1'b0);
        op(0, 1, 0, 4'd1, 8'hF5, 8'hFF, 8'h00, 1'b0);
        op(0, 1, 0, 4'd1, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        chk("reg1_changed_count", 32'(chg_cnt[0][1]), 32'd2);
        chk("exports_after_mask", a_exp, 32'h2000_F500);
        op(0, 0, 1, 4'd1, 8'h00, 8'h00, 8'hF5, 1'b0);
        idle(1);
        drain("masked");
        chk("a_err_none", 32'(err_cnt[0]), 32'd0);

        // Simultaneous write and read: write wins, read dropped.
        op(0, 1, 1, 4'd2, 8'h5A, 8'hFF, 8'h00, 1'b0);
        op(0, 0, 1, 4'd2, 8'h00, 8'h00, 8'h5A, 1'b0);
        idle(2);
        drain("wr_rd");
        chk("reg2_changed_count", 32'(chg_cnt[0][2]), 32'd1);
        chk("exports_after_wr_rd", a_exp, 32'h205A_F500);
        chk("a_err_still_none", 32'(err_cnt[0]), 32'd0);

        // Read-only register on dut_b.
        op(1, 1, 0, 4'd3, 8'h10, 8'hFF, 8'h00, 1'b0);
        idle(2);
        chk("ro_err_count", 32'(err_cnt[1]), 32'd1);
        chk("ro_no_change", 32'(chg_cnt[1][3]), 32'd0);
        chk("ro_exports", b_exp, 32'h2000_0000);
        op(1, 0, 1, 4'd3, 8'h00, 8'h00, 8'd32, 1'b0);
        idle(1);
        drain("ro_read");

        // Out-of-range addresses with DEPTH=12.
        op(1, 0, 1, 4'd13, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(1);
        drain("oob_read");
        op(1, 1, 0, 4'd12, 8'hFF, 8'hFF, 8'h00, 1'b0);
        idle(2);
        chk("oob_err_count", 32'(err_cnt[1]), 32'd3);

        // Back-to-back reads, latency 2.
        op(1, 0, 1, 4'd4, 8'h00, 8'h00, 8'h44, 1'b0);
        op(1, 0, 1, 4'd5, 8'h00, 8'h00, 8'h55, 1'b0);
        op(1, 0, 1, 4'd6, 8'h00, 8'h00, 8'h66, 1'b0);
        idle(1);
        drain("pipelined");

        // Reset while reads are in flight: nothing may come out afterwards.
        op(1, 0, 1, 4'd7, 8'h00, 8'h00, 8'h77, 1'b0);
        op(1, 0, 1, 4'd8, 8'h00, 8'h00, 8'h88, 1'b0);
        rd_en[1] = 1'b0;
        q1.delete();
        rst_n[1] = 1'b0;
        idle(2);
        rst_n[1] = 1'b1;
        idle(5);
        chk("flush_pending", 32'(q1.size()), 32'd0);
        chk("flush_err_count", 32'(err_cnt[1]), 32'd3);
        chk("flush_exports", b_exp, 32'h2000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
